// File: rtl/operand_fetch_if.sv
// Issue-stage bus: decoded-instruction handshake, ALU operand/result lanes
// and the debug register-file read port, bundled for operand_fetch.
interface operand_fetch_if #(
    parameter int AW = 3
);
    // instruction handshake
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [2:0]    in_shamt;
    logic [AW-1:0] in_ra;
    logic [AW-1:0] in_rb;
    logic [AW-1:0] in_rd;
    logic          in_we;
    logic          in_use_imm;
    logic [7:0]    in_imm;
    logic          flush;

    // ALU side
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_op;
    logic [2:0]    alu_shamt;
    logic [7:0]    alu_out;

    // debug read port
    logic [AW-1:0] dbg_addr;
    logic [7:0]    dbg_data;

    // decoder / ALU model side
    modport master (
        output in_valid, in_op, in_shamt, in_ra, in_rb, in_rd,
               in_we, in_use_imm, in_imm, flush, alu_out, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_op, alu_shamt, dbg_data
    );

    // operand-fetch stage side
    modport slave (
        input  in_valid, in_op, in_shamt, in_ra, in_rb, in_rd,
               in_we, in_use_imm, in_imm, flush, alu_out, dbg_addr,
        output in_ready, alu_a, alu_b, alu_op, alu_shamt, dbg_data
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage in front of the 8-bit ALU.
// Owns the register file, reads or bypasses operands, registers them onto the
// ALU inputs and writes the ALU result back two edges after issue. A consumer
// of the instruction issued on the previous edge is held off for one cycle,
// after which the result is picked up from alu_out through the bypass.
module operand_fetch #(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input logic           clk,
    input logic           rst,
    operand_fetch_if.slave bus
);

    // register file contents, one flop bank per register below
    logic [7:0]    w_regs [NREGS];

    // s1: instruction on the ALU inputs; s2: instruction whose result is on alu_out
    logic          r_s1_valid;
    logic          r_s1_we;
    logic [AW-1:0] r_s1_rd;
    logic          r_s2_valid;
    logic          r_s2_we;
    logic [AW-1:0] r_s2_rd;

    // registered ALU operands
    logic [7:0]    r_alu_a;
    logic [7:0]    r_alu_b;
    logic [2:0]    r_alu_op;
    logic [2:0]    r_alu_shamt;

    logic          w_hz;
    logic          w_ready;
    logic          w_accept;
    logic          w_s2_writes;
    logic          w_wb_en;
    logic          w_byp_a;
    logic          w_byp_b;
    logic [7:0]    w_read_a;
    logic [7:0]    w_read_b;
    logic [7:0]    w_op_b;

    // The previous-edge producer's result does not exist yet, so a consumer
    // must wait one cycle. Operand B only counts when it actually comes from
    // the register file.
    assign w_hz = r_s1_valid && r_s1_we &&
                  ((bus.in_ra == r_s1_rd) ||
                   (!bus.in_use_imm && (bus.in_rb == r_s1_rd)));

    assign w_ready      = !w_hz && !bus.flush;
    assign w_accept     = bus.in_valid && w_ready;
    assign bus.in_ready = w_ready;

    // A result sitting on alu_out is the newest value of s2.rd; it is also what
    // gets written this cycle, so a same-cycle reader sees the new value.
    assign w_s2_writes = r_s2_valid && r_s2_we;
    assign w_wb_en     = w_s2_writes && !bus.flush;
    assign w_byp_a     = w_s2_writes && (r_s2_rd == bus.in_ra);
    assign w_byp_b     = w_s2_writes && (r_s2_rd == bus.in_rb);
    assign w_read_a    = w_byp_a ? bus.alu_out : w_regs[bus.in_ra];
    assign w_read_b    = w_byp_b ? bus.alu_out : w_regs[bus.in_rb];
    assign w_op_b      = bus.in_use_imm ? bus.in_imm : w_read_b;

    // One bank per architectural register; every address is writable.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [7:0] r_q;
        logic       w_wen;

        assign w_wen = w_wb_en && (r_s2_rd == AW'(gi));

        // writeback of the s2 result into this register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_wen) begin
                r_q <= bus.alu_out;
            end
        end

        assign w_regs[gi] = r_q;
    end

    // advance the in-flight tracking; flush kills both slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_rd    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_we    <= 1'b0;
            r_s2_rd    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_we    <= bus.in_we;
            r_s1_rd    <= bus.in_rd;
            r_s2_valid <= r_s1_valid && !bus.flush;
            r_s2_we    <= r_s1_we;
            r_s2_rd    <= r_s1_rd;
        end
    end

    // load the ALU operands on accept, otherwise hold them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_shamt <= '0;
        end else if (w_accept) begin
            r_alu_a     <= w_read_a;
            r_alu_b     <= w_op_b;
            r_alu_op    <= bus.in_op;
            r_alu_shamt <= bus.in_shamt;
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_shamt = r_alu_shamt;

    // debug view of the register file, before any same-cycle writeback
    assign bus.dbg_data = w_regs[bus.dbg_addr];

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: plays the decoder and a registered ALU, and keeps an
// architectural (program-order) register model to predict operands and contents.
`timescale 1ns/1ps
module tb_operand_fetch;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // architectural register state, updated in program order at issue
    logic [7:0] model_regs [8];

    operand_fetch_if #(.AW(AW)) bus ();

    operand_fetch #(.NREGS(8), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [2:0] sh,
                                         input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return a >> sh;
            default: return a;
        endcase
    endfunction

    // registered ALU: result appears the cycle after the operands
    always @(posedge clk or posedge rst) begin
        if (rst) bus.alu_out <= 8'd0;
        else     bus.alu_out <= alu_f(bus.alu_op, bus.alu_shamt, bus.alu_a, bus.alu_b);
    end

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_op      = 3'd0;
        bus.in_shamt   = 3'd0;
        bus.in_ra      = 3'd0;
        bus.in_rb      = 3'd0;
        bus.in_rd      = 3'd0;
        bus.in_we      = 1'b0;
        bus.in_use_imm = 1'b0;
        bus.in_imm     = 8'd0;
        bus.flush      = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction and hold it until accepted. Entered and left at
    // posedge+1ns; on return the instruction has just been accepted.
    task automatic issue(input logic [2:0] op, input logic [2:0] sh,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                         input logic we, input logic use_imm, input logic [7:0] imm,
                         output int stalls, output logic [7:0] exp_a, output logic [7:0] exp_b);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_shamt   = sh;
        bus.in_ra      = ra;
        bus.in_rb      = rb;
        bus.in_rd      = rd;
        bus.in_we      = we;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
        exp_a  = model_regs[ra];
        exp_b  = use_imm ? imm : model_regs[rb];
        stalls = 0;
        #1;
        while (!bus.in_ready && stalls < 4) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_timeout in_ready=%b required=1 after %0d cycles", bus.in_ready, stalls);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (we) model_regs[rd] = alu_f(op, sh, exp_a, exp_b);
        $display("issue op=%0d ra=%0d rb=%0d rd=%0d we=%0b imm_sel=%0b imm=%02h stalls=%0d a=%02h b=%02h",
                 op, ra, rb, rd, we, use_imm, imm, stalls, bus.alu_a, bus.alu_b);
    endtask

    task automatic test_reset();
        int s;
        logic [7:0] ea, eb;
        // state while reset is held from power-up
        n_cmp++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_alu got a=%h b=%h op=%h sh=%h required all 0",
                     bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got=%b required=1", bus.in_ready);
        end
        rst = 1'b0;
        cycles(1);
        // two in-flight instructions, then reset lands mid-stream
        issue(3'd4, 3'd5, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 8'h33, s, ea, eb);
        issue(3'd4, 3'd6, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 8'h44, s, ea, eb);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt} !== 22'd0) begin
            n_fail++;
            $display("FAIL midreset_alu got a=%h b=%h op=%h sh=%h required all 0",
                     bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt);
        end
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = i[2:0];
            #0.1;
            n_cmp++;
            if (bus.dbg_data !== 8'd0) begin
                n_fail++;
                $display("FAIL midreset_reg%0d got=%h required=00", i, bus.dbg_data);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(3);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = i[2:0];
            #0.1;
            n_cmp++;
            if (bus.dbg_data !== 8'd0) begin
                n_fail++;
                $display("FAIL postreset_reg%0d got=%h required=00", i, bus.dbg_data);
            end
            model_regs[i] = 8'd0;
        end
    endtask

    task automatic test_add_independent();
        int s1, s2;
        logic [7:0] ea, eb;
        issue(3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 8'd5, s1, ea, eb);
        issue(3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 8'd7, s1, ea, eb);
        cycles(3);
        issue(3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 8'd0, s1, ea, eb);
        n_cmp++;
        if (bus.alu_a !== 8'd5 || bus.alu_b !== 8'd7) begin
            n_fail++;
            $display("FAIL add_operands got a=%h b=%h required a=05 b=07", bus.alu_a, bus.alu_b);
        end
        issue(3'd2, 3'd0, 3'd5, 3'd6, 3'd7, 1'b1, 1'b0, 8'd0, s2, ea, eb);
        n_cmp++;
        if (s1 != 0 || s2 != 0) begin
            n_fail++;
            $display("FAIL add_no_stall got stalls=%0d,%0d required 0,0", s1, s2);
        end
        bus.dbg_addr = 3'd1;
        #0.1;
        n_cmp++;
        if (bus.dbg_data !== 8'd0) begin
            n_fail++;
            $display("FAIL add_r1_early got=%h required=00", bus.dbg_data);
        end
        cycles(1);
        n_cmp++;
        if (bus.dbg_data !== 8'd12) begin
            n_fail++;
            $display("FAIL add_r1_written got=%h required=0c", bus.dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [7:0] ea, eb;
        issue(3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 8'h10, s, ea, eb);
        cycles(3);
        issue(3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 8'd0, s, ea, eb);
        issue(3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 1'b1, 1'b0, 8'd0, s, ea, eb);
        n_cmp++;
        if (s != 1) begin
            n_fail++;
            $display("FAIL b2b_stall got=%0d required=1", s);
        end
        n_cmp++;
        if (bus.alu_a !== 8'd12 || bus.alu_b !== 8'd12) begin
            n_fail++;
            $display("FAIL b2b_bypass got a=%h b=%h required a=0c b=0c", bus.alu_a, bus.alu_b);
        end
        cycles(2);
        bus.dbg_addr = 3'd4;
        #0.1;
        n_cmp++;
        if (bus.dbg_data !== 8'd24) begin
            n_fail++;
            $display("FAIL b2b_r4 got=%h required=18", bus.dbg_data);
        end
    endtask

    task automatic test_imm_no_stall();
        int s;
        logic [7:0] ea, eb;
        issue(3'd0, 3'd0, 3'd2, 3'd0, 3'd6, 1'b1, 1'b1, 8'd1, s, ea, eb);
        issue(3'd2, 3'd0, 3'd5, 3'd6, 3'd3, 1'b1, 1'b1, 8'hA5, s, ea, eb);
        n_cmp++;
        if (s != 0) begin
            n_fail++;
            $display("FAIL imm_stall got=%0d required=0", s);
        end
        n_cmp++;
        if (bus.alu_b !== 8'hA5 || bus.alu_a !== ea) begin
            n_fail++;
            $display("FAIL imm_operands got a=%h b=%h required a=%h b=a5", bus.alu_a, bus.alu_b, ea);
        end
        cycles(2);
    endtask

    task automatic test_flush();
        int s;
        logic [7:0] ea, eb, old_r1;
        old_r1 = model_regs[1];
        issue(3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 8'hFF, s, ea, eb);
        model_regs[1] = old_r1;
        bus.flush      = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_ra      = 3'd5;
        bus.in_rb      = 3'd6;
        bus.in_rd      = 3'd7;
        bus.in_we      = 1'b1;
        bus.in_use_imm = 1'b1;
        bus.in_imm     = 8'h3C;
        #0.1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready_low got=%b required=0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #0.1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready_after got=%b required=1", bus.in_ready);
        end
        n_cmp++;
        if (bus.alu_a !== 8'd0 || bus.alu_b !== 8'hFF) begin
            n_fail++;
            $display("FAIL flush_alu_hold got a=%h b=%h required a=00 b=ff", bus.alu_a, bus.alu_b);
        end
        cycles(3);
        bus.dbg_addr = 3'd1;
        #0.1;
        n_cmp++;
        if (bus.dbg_data !== old_r1) begin
            n_fail++;
            $display("FAIL flush_r1 got=%h required=%h", bus.dbg_data, old_r1);
        end
        bus.dbg_addr = 3'd7;
        #0.1;
        n_cmp++;
        if (bus.dbg_data !== model_regs[7]) begin
            n_fail++;
            $display("FAIL flush_r7 got=%h required=%h", bus.dbg_data, model_regs[7]);
        end
    endtask

    task automatic test_no_we();
        int s;
        logic [7:0] ea, eb;
        issue(3'd1, 3'd0, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0, 8'd0, s, ea, eb);
        issue(3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 1'b1, 1'b0, 8'd0, s, ea, eb);
        n_cmp++;
        if (s != 0) begin
            n_fail++;
            $display("FAIL nowe_stall got=%0d required=0", s);
        end
        n_cmp++;
        if (bus.alu_a !== 8'd5) begin
            n_fail++;
            $display("FAIL nowe_operand got=%h required=05", bus.alu_a);
        end
        cycles(3);
        bus.dbg_addr = 3'd2;
        #0.1;
        n_cmp++;
        if (bus.dbg_data !== 8'd5) begin
            n_fail++;
            $display("FAIL nowe_r2 got=%h required=05", bus.dbg_data);
        end
    endtask

    task automatic test_random();
        int s, exp_s;
        logic [7:0] ea, eb, imm;
        logic [2:0] op, sh, ra, rb, rd;
        logic we, use_imm, prev_ok, prev_we;
        logic [2:0] prev_rd;
        prev_ok = 1'b0;
        prev_we = 1'b0;
        prev_rd = 3'd0;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cycles(1);
                prev_ok = 1'b0;
            end
            op      = 3'($urandom_range(0, 7));
            sh      = 3'($urandom_range(0, 7));
            ra      = 3'($urandom_range(0, 7));
            rb      = 3'($urandom_range(0, 7));
            rd      = 3'($urandom_range(0, 7));
            we      = ($urandom_range(0, 4) != 0);
            use_imm = ($urandom_range(0, 2) == 0);
            imm     = 8'($urandom);
            exp_s = (prev_ok && prev_we && (prev_rd == ra || (!use_imm && prev_rd == rb))) ? 1 : 0;
            issue(op, sh, ra, rb, rd, we, use_imm, imm, s, ea, eb);
            n_cmp++;
            if (s != exp_s) begin
                n_fail++;
                $display("FAIL rand%0d_stall got=%0d required=%0d", n, s, exp_s);
            end
            n_cmp++;
            if (bus.alu_a !== ea || bus.alu_b !== eb || bus.alu_op !== op || bus.alu_shamt !== sh) begin
                n_fail++;
                $display("FAIL rand%0d_alu got a=%h b=%h op=%0d sh=%0d required a=%h b=%h op=%0d sh=%0d",
                         n, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt, ea, eb, op, sh);
            end
            prev_ok = 1'b1;
            prev_we = we;
            prev_rd = rd;
        end
        cycles(3);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = i[2:0];
            #0.1;
            n_cmp++;
            if (bus.dbg_data !== model_regs[i]) begin
                n_fail++;
                $display("FAIL rand_final_reg%0d got=%h required=%h", i, bus.dbg_data, model_regs[i]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.dbg_addr = 3'd0;
        for (int i = 0; i < 8; i++) model_regs[i] = 8'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_add_independent();
        test_back_to_back();
        test_imm_no_stall();
        test_flush();
        test_no_we();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
